// File: rtl/drum_pkg.sv
// Shared definitions for the DRUM6 approximate sequential divider.
// Optional build macro: DRUM_DIV_ROUND_EN (round-half-up output shift).
package drum_pkg;

    localparam int WIDTH = 16;            // operand / quotient width
    localparam int K     = 6;             // kept mantissa bits, forced-one LSB included
    localparam int G     = WIDTH - K;     // guard bits appended to the dividend mantissa
    localparam int CNT_W = 4;             // iteration counter width
    localparam int S_W   = 4;             // per-operand exponent width
    localparam int R_W   = 5;             // final shift amount width (0..G+WIDTH-K)

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] Q_SAT    = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        DIV,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/drum_norm.sv
// DRUM dynamic-range truncation of one operand: leading-one detect,
// keep K MSBs with the LSB forced to 1, report the dropped bit count.
module drum_norm
    import drum_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    output logic [K-1:0]     mx,
    output logic [S_W-1:0]   sx
);

    logic [S_W-1:0] kx;

    // Priority-encode the leading one, then truncate when it sits at or above bit K
    always_comb begin
        kx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (x[i]) kx = S_W'(i);
        end
        mx = x[K-1:0];
        sx = '0;
        if (kx >= S_W'(K)) begin
            sx = kx - S_W'(K - 1);
            mx = {x[kx -: K-1], 1'b1};
        end
    end

endmodule

// File: rtl/drum6_div_16_seq.sv
// DRUM6 approximate unsigned divider q ~= a / b for gain normalisation.
// Both operands are DRUM-truncated, the mantissas divided by a radix-2
// restoring loop (one bit per cycle), then the exponent difference is
// applied as a right shift.
// Build macro DRUM_DIV_ROUND_EN: round half up in the final shift.
module drum6_div_16_seq
    import drum_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic             dz
);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  dq_q, dq_d;       // dividend shifts out MSB-first, quotient shifts in
    logic [K-1:0]      rem_q, rem_d;
    logic [K-1:0]      mb_q, mb_d;
    logic [R_W-1:0]    r_q, r_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              dz_q, dz_d;

    logic [K-1:0]      ma_n, mb_n;
    logic [S_W-1:0]    sa_n, sb_n;
    logic [K:0]        trial, diff;
    logic [WIDTH-1:0]  q_shift;

    drum_norm u_norm_a (.x(a_q), .mx(ma_n), .sx(sa_n));
    drum_norm u_norm_b (.x(b_q), .mx(mb_n), .sx(sb_n));

    // Control state: cleared by reset in any state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
        end
    end

    // Datapath registers: only meaningful once loaded, so no reset needed
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        dq_q  <= dq_d;
        rem_q <= rem_d;
        mb_q  <= mb_d;
        r_q   <= r_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = NORM;
            NORM:    state_d = (b_q == '0) ? DONE : DIV;
            DIV:     if (cnt_q == CNT_LAST) state_d = SHIFT;
            SHIFT:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Final scaling of the mantissa quotient by the exponent difference
    always_comb begin
`ifdef DRUM_DIV_ROUND_EN
        logic [21:0] sum;
        logic [21:0] shifted;
        sum = {6'b0, dq_q};
        if (r_q != '0) sum = sum + (22'd1 << (r_q - R_W'(1)));
        shifted = sum >> r_q;
        q_shift = (|shifted[21:16]) ? Q_SAT : shifted[15:0];
`else
        q_shift = (r_q >= R_W'(WIDTH)) ? '0 : (dq_q >> r_q);
`endif
    end

    // Datapath updates per state: capture, normalise, divide step, scale
    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        dq_d  = dq_q;
        rem_d = rem_q;
        mb_d  = mb_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        q_d   = q_q;
        dz_d  = dz_q;
        trial = {rem_q, dq_q[WIDTH-1]};
        diff  = trial - {1'b0, mb_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d = a;
                    b_d = b;
                end
            end
            NORM: begin
                dq_d  = {ma_n, {G{1'b0}}};
                mb_d  = mb_n;
                r_d   = R_W'(G) + R_W'(sb_n) - R_W'(sa_n);
                rem_d = '0;
                cnt_d = '0;
                if (b_q == '0) begin
                    q_d  = Q_SAT;
                    dz_d = 1'b1;
                end
            end
            DIV: begin
                if (trial >= {1'b0, mb_q}) begin
                    rem_d = diff[K-1:0];
                    dq_d  = {dq_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial[K-1:0];
                    dq_d  = {dq_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
            end
            SHIFT: begin
                q_d  = q_shift;
                dz_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Handshake and result outputs decoded from state
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        q         = q_q;
        dz        = dz_q;
    end

endmodule

// File: tb/tb_drum6_div_16_seq.sv
// Randomised self-checking bench for drum6_div_16_seq against an
// arithmetic reference model of the DRUM divide rules.
module tb_drum6_div_16_seq;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, dz;
    logic [15:0] a, b, q;
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    drum6_div_16_seq dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q(q), .dz(dz)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Mantissa/exponent of one operand: top 6 significant bits, LSB forced to 1
    function automatic void norm_ref(input int x, output int m, output int s);
        int k;
        if (x < 64) begin
            m = x;
            s = 0;
        end else begin
            k = 0;
            while ((x >> (k + 1)) != 0) k++;
            s = k - 5;
            m = (x >> s) | 1;
        end
    endfunction

    function automatic void model(input int xa, input int xb, output int qe, output int dze);
        int ma, sa, mb, sb, t, r, v;
        if (xb == 0) begin
            qe  = 65535;
            dze = 1;
            return;
        end
        norm_ref(xa, ma, sa);
        norm_ref(xb, mb, sb);
        t   = (ma * 1024) / mb;
        r   = 10 + sb - sa;
        dze = 0;
`ifdef DRUM_DIV_ROUND_EN
        if (r == 0) v = t;
        else        v = (t + (1 << (r - 1))) >> r;
        qe = (v > 65535) ? 65535 : v;
`else
        qe = (r >= 16) ? 0 : (t >> r);
`endif
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input bit hold);
        int n, qe, dze, lat;
        logic [15:0] q_seen;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_op", in_ready, 1);
        @(negedge clk);
        a = ta; b = tb_v; in_valid = 1'b1;
        @(posedge clk); #1;                      // acceptance edge E
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
        model(int'(ta), int'(tb_v), qe, dze);
        lat = (tb_v == 0) ? 1 : 18;
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("latency", n, lat);
        chk("q", q, qe);
        chk("dz", dz, dze);
        if (hold) begin
            q_seen = q;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom);
                @(posedge clk); #1;
                chk("hold_q", q_seen, qe);
                chk("hold_q_now", q, qe);
                chk("hold_in_ready", in_ready, 0);
                chk("hold_out_valid", out_valid, 1);
            end
            in_valid = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ready_after_accept", in_ready, 1);
        chk("valid_after_accept", out_valid, 0);
    endtask

    initial begin
        int wa, wb;
        logic [15:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q", q, 0);
        chk("rst_dz", dz, 0);
        chk("rst_in_ready", in_ready, 1);

        run_op(16'd1000, 16'd10, 1'b1);          // includes back-pressure hold
        run_op(16'd63, 16'd7, 1'b0);
        run_op(16'd65535, 16'd1, 1'b0);
        run_op(16'd500, 16'd0, 1'b0);
        run_op(16'd0, 16'd5, 1'b0);
        run_op(16'd0, 16'd0, 1'b0);
        run_op(16'd65535, 16'd65535, 1'b0);
        run_op(16'd1, 16'd65535, 1'b0);

        // Reset mid-divide
        @(negedge clk);
        a = 16'd1000; b = 16'd10; in_valid = 1'b1;
        @(posedge clk); #1;                      // E
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;                      // E+8
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_q", q, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk); rst = 1'b0;
        run_op(16'd63, 16'd7, 1'b0);

        for (int i = 0; i < 60; i++) begin
            wa = $urandom_range(0, 16);
            wb = $urandom_range(0, 16);
            ra = 16'($urandom & ((32'h1 << wa) - 1));
            rb = 16'($urandom & ((32'h1 << wb) - 1));
            run_op(ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
